// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/issue sequencer for an 18-bit instruction ROM
// Owns the PC, decodes each word and hands it to the datapath over valid/ready.
module instr_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 18,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  address,
    output logic               dp_valid,
    input  logic               dp_ready,
    output logic [1:0]         dp_op,
    output logic [3:0]         dp_fa,
    output logic [3:0]         dp_fb,
    output logic [3:0]         dp_fc,
    output logic [3:0]         dp_fd,
    input  logic               dp_done,
    input  logic               dp_zero,
    output logic               busy,
    output logic               halted,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_HALT   = 2'b11;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic                r_valid;
    logic [7:0]          r_wait_cnt;
    logic [CNT_W-1:0]    r_retired;

    logic [1:0]          w_op;
    logic                w_branch_taken;

    assign w_op           = r_ir[17:16];
    assign w_branch_taken = (w_op == OP_BRANCH) && dp_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_valid    <= 1'b0;
            r_wait_cnt <= '0;
            r_retired  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir <= instruction;
                    // Halts are terminal: never offered to the datapath, never retired.
                    if (instruction[17:16] == OP_HALT) begin
                        r_state <= S_HALT;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dp_ready) begin
                        r_valid    <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (dp_done) begin
                        if (r_retired != {CNT_W{1'b1}}) begin
                            r_retired <= r_retired + 1'b1;
                        end
                        if (w_branch_taken) begin
                            r_pc <= r_ir[ADDR_W-1:0];
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                        r_state <= S_FETCH;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_HALT, S_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign address     = r_pc;
    assign dp_valid    = r_valid;
    assign dp_op       = r_ir[17:16];
    assign dp_fa       = r_ir[15:12];
    assign dp_fb       = r_ir[11:8];
    assign dp_fc       = r_ir[7:4];
    assign dp_fd       = r_ir[3:0];
    assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign halted      = (r_state == S_HALT);
    assign timeout_err = (r_state == S_ERR);
    assign retired     = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized bench for instr_sequencer against a reference model
module tb_instr_sequencer;

    localparam int TO = 16;
    localparam int M_IDLE = 0, M_FETCH = 1, M_ISSUE = 2, M_WAIT = 3, M_HALT = 4, M_ERR = 5;

    logic        clk;
    logic        rst;
    logic        start;
    logic [17:0] instruction;
    logic [4:0]  address;
    logic        dp_valid;
    logic        dp_ready;
    logic [1:0]  dp_op;
    logic [3:0]  dp_fa, dp_fb, dp_fc, dp_fd;
    logic        dp_done;
    logic        dp_zero;
    logic        busy, halted, timeout_err;
    logic [7:0]  retired;

    logic [17:0] rom [32];
    assign instruction = rom[address];

    instr_sequencer #(.ADDR_W(5), .INSTR_W(18), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction), .address(address),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_op(dp_op),
        .dp_fa(dp_fa), .dp_fb(dp_fb), .dp_fc(dp_fc), .dp_fd(dp_fd),
        .dp_done(dp_done), .dp_zero(dp_zero), .busy(busy), .halted(halted),
        .timeout_err(timeout_err), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 0;

    // Reference model: the program's architectural view of execution.
    int          m_st, m_pc, m_wc, m_ret;
    logic [17:0] m_ir;

    // Stimulus policy.
    int a_ready_pct = 100;
    int a_zero = 0;
    bit a_start = 0, a_start_rand = 0, a_done_first = 1, a_nodone = 0, a_junk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_pc = 0; m_wc = 0; m_ret = 0; m_ir = '0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        case (m_st)
            M_IDLE:  if (start) begin m_st = M_FETCH; m_pc = 0; end
            M_FETCH: begin
                m_ir = rom[m_pc];
                m_st = (m_ir[17:16] == 2'b11) ? M_HALT : M_ISSUE;
            end
            M_ISSUE: if (dp_ready) begin m_st = M_WAIT; m_wc = 0; end
            M_WAIT: begin
                if (dp_done) begin
                    if (m_ret < 255) m_ret++;
                    if (m_ir[17:16] == 2'b10 && dp_zero) m_pc = int'(m_ir[4:0]);
                    else m_pc = (m_pc + 1) % 32;
                    m_st = M_FETCH;
                end else if (m_wc + 1 == TO) begin
                    m_st = M_ERR;
                end else begin
                    m_wc++;
                end
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("address", address, m_pc);
            chk("dp_valid", dp_valid, m_st == M_ISSUE);
            chk("dp_op", dp_op, m_ir[17:16]);
            chk("dp_fa", dp_fa, m_ir[15:12]);
            chk("dp_fb", dp_fb, m_ir[11:8]);
            chk("dp_fc", dp_fc, m_ir[7:4]);
            chk("dp_fd", dp_fd, m_ir[3:0]);
            chk("busy", busy, m_st == M_FETCH || m_st == M_ISSUE || m_st == M_WAIT);
            chk("halted", halted, m_st == M_HALT);
            chk("timeout_err", timeout_err, m_st == M_ERR);
            chk("retired", retired, m_ret);
        end
    end

    task automatic drive();
        start    = a_start_rand ? 1'($urandom % 2) : a_start;
        dp_ready = int'($urandom % 100) < a_ready_pct;
        if (m_st == M_WAIT)
            dp_done = a_nodone ? 1'b0 : (a_done_first ? 1'b1 : (($urandom % 3 == 0) || m_wc >= 8));
        else
            dp_done = a_junk ? ($urandom % 4 == 0) : 1'b0;
        dp_zero  = (a_zero == 2) ? 1'($urandom % 2) : (a_zero != 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin drive(); step(); end
    endtask

    task automatic run_until_st(input int st, input int budget);
        int k = 0;
        while (m_st != st && k < budget) begin drive(); step(); k++; end
        chk("bound_state", m_st, st);
    endtask

    task automatic run_until_ret(input int n, input int budget);
        int k = 0;
        while (m_ret < n && k < budget) begin drive(); step(); k++; end
        chk("bound_retired", m_ret, n);
    endtask

    // Asserted between edges; outputs must clear before the next edge arrives.
    task automatic do_reset();
        start = 0; dp_ready = 0; dp_done = 0; dp_zero = 0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_address", address, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_fields", {dp_op, dp_fa, dp_fb, dp_fc, dp_fd}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_retired", retired, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic start_run();
        a_start = 1; drive(); step(); a_start = 0;
    endtask

    task automatic fill_straight();
        for (int i = 0; i < 32; i++) rom[i] = {1'b0, 1'($urandom % 2), 16'($urandom)};
    endtask

    initial begin
        rst = 0; start = 0; dp_ready = 0; dp_done = 0; dp_zero = 0;
        model_reset();
        fill_straight();
        #2;
        do_reset();
        cmp_en = 1;

        // Basic throughput: FETCH, ISSUE, WAIT per instruction.
        rom[0] = {2'b00, 16'hA5C3};
        start_run();
        chk("t1_addr0", address, 0);
        chk("t1_busy", busy, 1);
        run(1);
        chk("t1_valid", dp_valid, 1);
        chk("t1_op", dp_op, 0);
        chk("t1_fa", dp_fa, 4'hA);
        run(1);
        chk("t1_valid_drop", dp_valid, 0);
        run(1);
        chk("t1_addr1", address, 1);
        chk("t1_retired", retired, 1);

        // Branch taken and not taken.
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            fill_straight();
            rom[3] = 18'b10_0001_0010_0010_1001;
            a_zero = z;
            start_run();
            run_until_ret(4, 100);
            chk("t2_branch_addr", address, z ? 9 : 4);
        end
        a_zero = 0;

        // Indefinite ISSUE stall.
        do_reset();
        a_ready_pct = 0;
        start_run();
        run_until_st(M_ISSUE, 10);
        run(20);
        chk("t3_valid", dp_valid, 1);
        chk("t3_no_err", timeout_err, 0);
        chk("t3_fb", dp_fb, rom[0][11:8]);
        a_ready_pct = 100;
        run_until_ret(1, 20);
        chk("t3_retired", retired, 1);

        // dp_done on the last allowed WAIT cycle beats the timeout.
        do_reset();
        a_nodone = 1;
        start_run();
        run_until_st(M_WAIT, 20);
        run(TO - 1);
        a_nodone = 0;
        run(1);
        chk("t4_edge_no_err", timeout_err, 0);
        chk("t4_edge_retired", retired, 1);

        // Timeout after TIMEOUT WAIT cycles.
        do_reset();
        a_nodone = 1;
        start_run();
        run_until_st(M_WAIT, 20);
        run(TO - 1);
        chk("t4_not_yet", timeout_err, 0);
        run(1);
        chk("t4_err", timeout_err, 1);
        chk("t4_busy", busy, 0);
        chk("t4_retired", retired, 0);
        a_start = 1; run(5); a_start = 0;
        chk("t4_sticky", timeout_err, 1);
        a_nodone = 0;
        do_reset();

        // PC wrap and retired saturation.
        fill_straight();
        start_run();
        run_until_ret(32, 200);
        chk("t5_wrap", address, 0);
        run_until_ret(255, 1000);
        run(150);
        chk("t5_saturate", retired, 255);

        // Halt.
        do_reset();
        fill_straight();
        rom[2] = {2'b11, 16'h1234};
        start_run();
        run_until_st(M_HALT, 50);
        chk("t6_halted", halted, 1);
        chk("t6_addr", address, 2);
        chk("t6_retired", retired, 2);
        chk("t6_valid", dp_valid, 0);
        a_start = 1; run(5); a_start = 0;
        chk("t6_sticky", halted, 1);
        chk("t6_addr_hold", address, 2);

        // Randomized program and handshake timing.
        do_reset();
        for (int i = 0; i < 32; i++) rom[i] = {2'($urandom % 3), 16'($urandom)};
        a_start_rand = 1; a_ready_pct = 60; a_done_first = 0; a_junk = 1; a_zero = 2;
        run(3000);
        a_junk = 0;
        run_until_st(M_WAIT, 100);
        do_reset();
        run(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Fetch/issue controller for the 18-bit instruction ROM (5-bit address, combinational read) and the downstream execution datapath. Owns the program counter, drives the ROM address, and latches and decodes each instruction word. Hands each decoded instruction to the datapath over a valid/ready handshake, then waits for completion. Resolves branches and halts, and flags execution timeouts.

Parameters:
ADDR_W, 5, ROM address / PC width (32 words)
INSTR_W, 18, instruction width; op=[17:16], fa=[15:12], fb=[11:8], fc=[7:4], fd=[3:0]
TIMEOUT, 16, max cycles allowed in WAIT before dp_done; range 2..255
CNT_W, 8, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  level; begin execution from address 0 when in IDLE
instruction  in  INSTR_W  ROM read data, combinational from address
address  out  ADDR_W  ROM address (= current PC)
dp_valid  out  1  decoded instruction offered to datapath
dp_ready  in  1  datapath accepts when dp_valid & dp_ready on a clock edge
dp_op  out  2  latched op field
dp_fa, dp_fb, dp_fc, dp_fd  out  4 each  latched field nibbles
dp_done  in  1  single-cycle pulse: accepted instruction finished
dp_zero  in  1  datapath zero flag, sampled only with dp_done
busy  out  1  high in FETCH/ISSUE/WAIT
halted  out  1  high in HALT
timeout_err  out  1  high in ERR
retired  out  CNT_W  count of completed instructions, saturating

Behaviour:
- Reset (async, any state, mid-handshake included): state=IDLE, PC=0, instruction register=0, dp_valid=0, all dp_* fields=0, busy=0, halted=0, timeout_err=0, retired=0, wait counter=0.
- IDLE: address=PC. start=1 -> FETCH at the next edge, PC forced to 0.
- FETCH (1 cycle): latch instruction at the edge into the IR. Next state is HALT if op==2'b11, else ISSUE. A halt is not issued and not counted.
- ISSUE: dp_valid=1; dp_op/dp_f* come from the IR and are held stable while dp_valid=1. On dp_valid & dp_ready: dp_valid drops next cycle, wait counter=0, go to WAIT. There is no timeout in ISSUE; it may stall indefinitely.
- WAIT: wait counter increments each cycle.
  - dp_done=1: retired+1, saturating at all-ones. Branch rule: if op==2'b10 and dp_zero=1, PC <= IR[4:0]; otherwise PC <= PC+1. Then go to FETCH.
  - Counter reaches TIMEOUT-1 without dp_done: go to ERR. If dp_done arrives on that same cycle, dp_done wins.
- PC wrap: PC=31, +1 -> 0. Execution continues, no flag.
- Branch target equal to the current PC is legal (tight loop).
- HALT: halted=1, PC holds at the halt address, sticky. Only rst leaves HALT; start is ignored.
- ERR: timeout_err=1, dp_valid=0, sticky. Only rst leaves ERR.
- dp_done outside WAIT is ignored. dp_ready outside ISSUE is ignored.
- address always equals PC. The ROM is read combinationally, so the IR captures the word for the current PC in FETCH.
- Per-instruction throughput with ready=1 and done on the first WAIT cycle: FETCH, ISSUE, WAIT = 3 cycles.

Test Plan:
- Reset then start=1, ROM[0]=op00, dp_ready=1, dp_done pulsed the cycle after acceptance -> address 0 then 1; dp_op=0 on handshake; retired=1; FETCH of address 1 on the 3rd cycle after start.
- ROM[3]=op10 with IR[4:0]=5'd9: dp_zero=1 at done -> next address 9; repeat with dp_zero=0 -> next address 4.
- dp_ready held 0 for 20 cycles in ISSUE -> dp_valid stays 1 with fields stable, no timeout_err; ready=1 -> proceeds normally.
- In WAIT, withhold dp_done for TIMEOUT=16 cycles -> timeout_err=1 after 16 WAIT cycles, busy=0, retired unchanged; start has no effect; rst clears all.
- Straight-line ROM at PC=31 completes -> address wraps to 0; 300 completions -> retired saturates at 255.
- ROM[2]=op11 -> halted=1 after FETCH, address stays 2, dp_valid never asserted for it. Assert rst mid-WAIT on another run -> all outputs return to reset values asynchronously, before the next clock edge.
